if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the RV32IM pipeline. Owns the program counter, issues requests to instruction memory over a req/ack handshake, and drives the PC, PC+4 and instruction words into the IF/ID pipeline register. It honours a stall from the hazard unit and a taken-branch/jump redirect from EX. In-flight fetches made stale by a redirect are discarded.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: instruction word driven while no valid instruction is presented (addi x0,x0,0).
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- stall  input  1  IF/ID hold from the hazard unit; OUT_* must not change while high, except under redirect.
- branch_taken  input  1  redirect request from EX; one-cycle pulse.
- branch_target  input  32  redirect address; valid when branch_taken=1.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  input  1  response strobe; may be asserted in the same cycle as imem_req.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- OUT_pc  output  32  PC of the presented instruction; drives IN_pc of IF/ID.
- OUT_pc_plus_4  output  32  OUT_pc+4; drives IN_pc_plus_4.
- OUT_instruction  output  32  presented instruction; drives IN_instruction.
- OUT_valid  output  1  OUT_* carry a real instruction. 0 means bubble.

## Operation
- The FSM has four states: IDLE, WAIT, HOLD and DISCARD. The state, fetch PC, redirect PC, skid buffer and all OUT_* are registered.
- imem_req = (state==WAIT || state==DISCARD). It is decoded combinationally from the state.
- On reset:
  - state=IDLE, fetch PC and imem_addr = RESET_PC.
  - OUT_pc=0, OUT_pc_plus_4=0, OUT_instruction=NOP_INSTR, OUT_valid=0.
  - imem_req deasserts combinationally via IDLE. The memory shares this reset, so any outstanding transaction is abandoned.
- **IDLE**: go to WAIT on the next cycle (one dead cycle after reset).
- **WAIT**, imem_ack=1, no redirect, stall=0:
  - OUT_instruction←imem_rdata, OUT_pc←imem_addr, OUT_pc_plus_4←imem_addr+4, OUT_valid←1.
  - imem_addr←imem_addr+4; stay in WAIT.
- **WAIT**, imem_ack=1, stall=1: capture rdata and address into the skid buffer, go to HOLD, and leave OUT_* unchanged.
- **WAIT**, imem_ack=0: if stall=0, OUT_valid←0 and OUT_instruction←NOP_INSTR (bubble); OUT_pc and OUT_pc_plus_4 hold. If stall=1, all OUT_* hold.
- **HOLD** (imem_req=0): when stall=0, load OUT_* from the skid buffer with OUT_valid←1, set imem_addr←buffer address+4, and go to WAIT.
- **Redirect** (branch_taken=1) has priority over stall and ack in every state. It forces OUT_valid←0 and OUT_instruction←NOP_INSTR, and drops the skid buffer. The next state depends on the current state:
  - WAIT with ack=1: the response is dropped; imem_addr←branch_target; go to WAIT.
  - WAIT with ack=0: the request stays outstanding with its old address; redirect PC←branch_target; go to DISCARD.
  - HOLD: imem_addr←branch_target; go to WAIT.
  - DISCARD: redirect PC←branch_target (the latest target wins); stay in DISCARD.
  - IDLE: imem_addr←branch_target; go to WAIT.
- **DISCARD**: on imem_ack, drop rdata, set imem_addr←redirect PC, and go to WAIT.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] are passed through unchecked.

## Timing
- Data captured at the edge where imem_ack=1 appears on OUT_* after that same edge, one register stage.
- With a zero-wait memory (ack tied high while req is high), throughput is one instruction per cycle and PCs are consecutive.
- N wait cycles produce N bubble cycles (OUT_valid=0) when unstalled.
- The first valid OUT_* appears no earlier than the second posedge after reset deasserts.
- A redirect sampled at edge k produces OUT_valid=0 after edge k. With zero-wait memory, the target instruction appears after edge k+1.
- A stall covering the ack edge costs no refetch: the instruction leaves HOLD on the first edge with stall=0.

## Test plan
- **Reset and stream**: zero-wait memory returns 32'h1000_0000|addr, RESET_PC=0 → OUT_valid rises on the 2nd edge after reset. Then OUT_pc=0,4,8,…, with OUT_pc_plus_4=OUT_pc+4 and OUT_instruction matching each address.
- **Wait states**: ack delayed 2 cycles per request → 2 bubble cycles (OUT_valid=0, NOP_INSTR) between valid instructions, and imem_addr stable while waiting.
- **Stall over ack**: stall=1 for 3 cycles across the ack of addr 8 → OUT_* frozen on addr 4, imem_req=0 in HOLD. After release, OUT_pc=8 with correct data, then 12.
- **Redirect during outstanding request**: ack delayed 3 cycles, branch_taken with target 32'h200 mid-wait → DISCARD. The stale data never reaches OUT_valid=1; the next request is 32'h200 and the next valid OUT_pc=32'h200.
- **Simultaneous events**: branch_taken, stall and ack all high in one cycle → the flush wins (OUT_valid=0) and the next fetch address is the target. A second redirect while in DISCARD uses the latest target.
- **Edge cases**: reset asserted mid-WAIT → IDLE, OUT_valid=0, imem_req=0 the next cycle. Fetching from PC=32'hFFFF_FFFC → OUT_pc_plus_4=0 and the next imem_addr=0.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles every signal that crosses the boundary of the instruction-fetch stage:
// hazard/redirect controls, the instruction-memory req/ack channel and the
// IF/ID pipeline-register inputs.
//
// Handshake: imem_req is held high by the fetch unit until a cycle in which
// imem_ack is high. That cycle completes the transfer and imem_rdata is
// sampled in it. imem_addr is stable for as long as imem_req=1 and imem_ack=0.
// imem_ack may be high in the same cycle that imem_req first rises, so a
// zero-wait memory completes a fetch every cycle.
//
// modport slave  : the fetch unit itself
// modport master : the environment (hazard unit, EX, instruction memory, IF/ID)
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] OUT_pc;
    logic [31:0] OUT_pc_plus_4;
    logic [31:0] OUT_instruction;
    logic        OUT_valid;

    modport slave (
        input  stall, branch_taken, branch_target, imem_ack, imem_rdata,
        output imem_req, imem_addr, OUT_pc, OUT_pc_plus_4, OUT_instruction, OUT_valid
    );

    modport master (
        output stall, branch_taken, branch_target, imem_ack, imem_rdata,
        input  imem_req, imem_addr, OUT_pc, OUT_pc_plus_4, OUT_instruction, OUT_valid
    );
endinterface

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage of the RV32IM pipeline. Owns the program counter,
// fetches from instruction memory over a req/ack handshake and presents
// PC, PC+4 and the instruction word to the IF/ID register. Honours a stall from
// the hazard unit and redirects from EX; a fetch that is still outstanding when
// a redirect arrives is completed and its data thrown away.
//
// Ports:
//   clk         - single clock, all state changes on posedge
//   reset       - synchronous, active-high
//   bus         - if_fetch_unit_if.slave (controls, imem channel, OUT_* bus)
//   o_dbg_state - current FSM state (IDLE=0, WAIT=1, HOLD=2, DISCARD=3)
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    if_fetch_unit_if.slave        bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;     // address of the current/next request
    logic [31:0] r_redir_pc;     // target remembered while draining a stale fetch
    logic [31:0] r_skid_instr;   // response captured while stalled
    logic [31:0] r_skid_pc;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_pc_plus_4;
    logic [31:0] r_out_instr;
    logic        r_out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_fetch_pc      <= RESET_PC;
            r_redir_pc      <= RESET_PC;
            r_skid_instr    <= NOP_INSTR;
            r_skid_pc       <= RESET_PC;
            r_out_pc        <= 32'h0;
            r_out_pc_plus_4 <= 32'h0;
            r_out_instr     <= NOP_INSTR;
            r_out_valid     <= 1'b0;
        end else if (bus.branch_taken) begin
            // Flush beats stall and ack. Entering any state other than HOLD
            // implicitly drops whatever sits in the skid buffer.
            r_out_valid <= 1'b0;
            r_out_instr <= NOP_INSTR;
            case (r_state)
                WAIT: begin
                    if (bus.imem_ack) begin
                        r_fetch_pc <= bus.branch_target;
                        r_state    <= WAIT;
                    end else begin
                        // Request must finish at its old address first.
                        r_redir_pc <= bus.branch_target;
                        r_state    <= DISCARD;
                    end
                end
                DISCARD: begin
                    r_redir_pc <= bus.branch_target;
                    r_state    <= DISCARD;
                end
                default: begin // IDLE, HOLD: no request in flight
                    r_fetch_pc <= bus.branch_target;
                    r_state    <= WAIT;
                end
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        if (bus.stall) begin
                            r_skid_instr <= bus.imem_rdata;
                            r_skid_pc    <= r_fetch_pc;
                            r_state      <= HOLD;
                        end else begin
                            r_out_instr     <= bus.imem_rdata;
                            r_out_pc        <= r_fetch_pc;
                            r_out_pc_plus_4 <= r_fetch_pc + 32'd4;
                            r_out_valid     <= 1'b1;
                            r_fetch_pc      <= r_fetch_pc + 32'd4;
                        end
                    end else if (!bus.stall) begin
                        // Bubble; PC fields keep their last value.
                        r_out_valid <= 1'b0;
                        r_out_instr <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        r_out_instr     <= r_skid_instr;
                        r_out_pc        <= r_skid_pc;
                        r_out_pc_plus_4 <= r_skid_pc + 32'd4;
                        r_out_valid     <= 1'b1;
                        r_fetch_pc      <= r_skid_pc + 32'd4;
                        r_state         <= WAIT;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        r_fetch_pc <= r_redir_pc;
                        r_state    <= WAIT;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req        = (r_state == WAIT) || (r_state == DISCARD);
    assign bus.imem_addr       = r_fetch_pc;
    assign bus.OUT_pc          = r_out_pc;
    assign bus.OUT_pc_plus_4   = r_out_pc_plus_4;
    assign bus.OUT_instruction = r_out_instr;
    assign bus.OUT_valid       = r_out_valid;
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Bench for if_fetch_unit. Memory returns 32'h1000_0000 | addr, either with a
// programmable wait count (auto mode) or with ack driven by a vector table
// (manual mode). Presented instructions in auto mode are compared against an
// expected-PC queue.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [1:0]  dbg_state;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic        auto_mode;
    logic        man_ack;
    int unsigned mem_delay;
    int unsigned wait_cnt;

    assign bus.imem_ack   = auto_mode ? (bus.imem_req && (wait_cnt == mem_delay)) : man_ack;
    assign bus.imem_rdata = 32'h1000_0000 | bus.imem_addr;

    always @(posedge clk) begin
        if (reset || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
        else                                        wait_cnt <= wait_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic        sb_en;

    // A new instruction is presented after an edge where stall and reset
    // were low and OUT_valid is high.
    always begin
        logic s, r;
        logic [31:0] e;
        @(posedge clk);
        s = bus.stall;
        r = reset;
        #1;
        if (sb_en && bus.OUT_valid && !s && !r) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", bus.OUT_pc, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", bus.OUT_pc, e);
                check("sb_pc_plus_4", bus.OUT_pc_plus_4, e + 32'd4);
                check("sb_instr", bus.OUT_instruction, 32'h1000_0000 | e);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic        ack;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic [31:0] e_instr;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic logic [31:0] im(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    task automatic fill_table();
        //           rst   stl   br    ack   tgt            val   pc             p4             instr              req   addr
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         32'h0,         NOP,               1'b0,32'h0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         32'h0,         NOP,               1'b1,32'h0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h0,         32'h4,         im(32'h0),         1'b1,32'h4};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h4,         32'h8,         im(32'h4),         1'b1,32'h8};
        // stall over the ack of address 8
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,32'h0,         1'b1,32'h4,         32'h8,         im(32'h4),         1'b0,32'h8};
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,         1'b1,32'h4,         32'h8,         im(32'h4),         1'b0,32'h8};
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,         1'b1,32'h4,         32'h8,         im(32'h4),         1'b0,32'h8};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,         1'b1,32'h8,         32'hC,         im(32'h8),         1'b1,32'hC};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'hC,         32'h10,        im(32'hC),         1'b1,32'h10};
        // redirect while a request is outstanding; second redirect wins
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'hC,         32'h10,        NOP,               1'b1,32'h10};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0,32'h200,       1'b0,32'hC,         32'h10,        NOP,               1'b1,32'h10};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,32'h0,         1'b0,32'hC,         32'h10,        NOP,               1'b1,32'h10};
        tbl[12] = '{1'b0,1'b0,1'b1,1'b0,32'h300,       1'b0,32'hC,         32'h10,        NOP,               1'b1,32'h10};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b0,32'hC,         32'h10,        NOP,               1'b1,32'h300};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h300,       32'h304,       im(32'h300),       1'b1,32'h304};
        // branch, stall and ack together
        tbl[15] = '{1'b0,1'b1,1'b1,1'b1,32'h200,       1'b0,32'h300,       32'h304,       NOP,               1'b1,32'h200};
        tbl[16] = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h200,       32'h204,       im(32'h200),       1'b1,32'h204};
        // redirect out of HOLD to the top of the address space
        tbl[17] = '{1'b0,1'b1,1'b0,1'b1,32'h0,         1'b1,32'h200,       32'h204,       im(32'h200),       1'b0,32'h204};
        tbl[18] = '{1'b0,1'b1,1'b1,1'b0,32'hFFFF_FFFC, 1'b0,32'h200,       32'h204,       NOP,               1'b1,32'hFFFF_FFFC};
        tbl[19] = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'hFFFF_FFFC, 32'h0,         im(32'hFFFF_FFFC), 1'b1,32'h0};
        tbl[20] = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h0,         32'h4,         im(32'h0),         1'b1,32'h4};
        // stall without ack holds everything
        tbl[21] = '{1'b0,1'b1,1'b0,1'b0,32'h0,         1'b1,32'h0,         32'h4,         im(32'h0),         1'b1,32'h4};
        // reset mid-WAIT, then redirect straight out of IDLE
        tbl[22] = '{1'b1,1'b0,1'b0,1'b0,32'h0,         1'b0,32'h0,         32'h0,         NOP,               1'b0,32'h0};
        tbl[23] = '{1'b0,1'b0,1'b1,1'b0,32'h40,        1'b0,32'h0,         32'h0,         NOP,               1'b1,32'h40};
        tbl[24] = '{1'b0,1'b0,1'b0,1'b1,32'h0,         1'b1,32'h40,        32'h44,        im(32'h40),        1'b1,32'h44};
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_row(input vec_t v);
        @(negedge clk);
        reset             = v.rst;
        bus.stall         = v.stall;
        bus.branch_taken  = v.br;
        bus.branch_target = v.tgt;
        man_ack           = v.ack;
    endtask

    task automatic check_row(input int i, input vec_t v);
        check($sformatf("row%0d_valid", i), {31'h0, bus.OUT_valid}, {31'h0, v.e_valid});
        check($sformatf("row%0d_pc", i), bus.OUT_pc, v.e_pc);
        check($sformatf("row%0d_pc_plus_4", i), bus.OUT_pc_plus_4, v.e_p4);
        check($sformatf("row%0d_instr", i), bus.OUT_instruction, v.e_instr);
        check($sformatf("row%0d_req", i), {31'h0, bus.imem_req}, {31'h0, v.e_req});
        check($sformatf("row%0d_addr", i), bus.imem_addr, v.e_addr);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic found;
        n_checks          = 0;
        n_fail            = 0;
        sb_en             = 1'b0;
        reset             = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        man_ack           = 1'b0;
        auto_mode         = 1'b1;
        mem_delay         = 0;

        // --- reset state ---
        repeat (2) @(posedge clk);
        #2;
        check("reset_valid", {31'h0, bus.OUT_valid}, 32'h0);
        check("reset_pc", bus.OUT_pc, 32'h0);
        check("reset_pc_plus_4", bus.OUT_pc_plus_4, 32'h0);
        check("reset_instr", bus.OUT_instruction, NOP);
        check("reset_req", {31'h0, bus.imem_req}, 32'h0);
        check("reset_addr", bus.imem_addr, 32'h0);
        check("reset_state", {30'h0, dbg_state}, 32'h0);

        // --- zero-wait stream ---
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(k * 4));
        sb_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #2;
        check("stream_first_edge_bubble", {31'h0, bus.OUT_valid}, 32'h0);
        @(posedge clk); #2;
        check("stream_second_edge_valid", {31'h0, bus.OUT_valid}, 32'h1);
        repeat (7) @(posedge clk);
        #2;
        check("stream_back_to_back_drained", exp_q.size(), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #2;
        check("reset_mid_wait_req", {31'h0, bus.imem_req}, 32'h0);
        check("reset_mid_wait_valid", {31'h0, bus.OUT_valid}, 32'h0);

        // --- two wait states per request ---
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(k * 4));
        mem_delay = 2;
        @(negedge clk);
        reset = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(posedge clk); #2;
            if (bus.OUT_valid) found = 1'b1;
        end
        check("wait_first_valid_seen", {31'h0, found}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            check("wait_bubble_valid", {31'h0, bus.OUT_valid}, 32'h0);
            check("wait_bubble_instr", bus.OUT_instruction, NOP);
            check("wait_bubble_req", {31'h0, bus.imem_req}, 32'h1);
            check("wait_addr_stable", bus.imem_addr, 32'h4);
        end
        @(posedge clk); #2;
        check("wait_next_valid", {31'h0, bus.OUT_valid}, 32'h1);
        check("wait_next_pc", bus.OUT_pc, 32'h4);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk); #2;
        end
        check("wait_stream_drained", exp_q.size(), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #2;
        sb_en     = 1'b0;
        auto_mode = 1'b0;

        // --- table-driven multi-cycle corners ---
        fill_table();
        for (int i = 0; i < NV; i++) begin
            apply_row(tbl[i]);
            @(posedge clk); #2;
            check_row(i, tbl[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
